// File: rtl/find_best_hop_if.sv
// find_best_hop_if: start/parameter inputs, routing-table read bus and
// next-hop result signals of the best-hop search block.
interface find_best_hop_if;
  logic        en;
  logic [15:0] minBattery;
  logic [15:0] data_in;
  logic [15:0] address;
  logic        wr_en;
  logic [15:0] bestID;
  logic [15:0] bestQ;
  logic [15:0] bestCluster;
  logic [15:0] bestIndex;
  logic        noRoute;
  logic        done;

  modport master (
    output en, minBattery, data_in,
    input  address, wr_en, bestID, bestQ, bestCluster, bestIndex, noRoute, done
  );

  modport slave (
    input  en, minBattery, data_in,
    output address, wr_en, bestID, bestQ, bestCluster, bestIndex, noRoute, done
  );
endinterface

// File: rtl/find_best_hop.sv
// find_best_hop: scans the neighbour routing table for the battery-qualified
// neighbour with the lowest qValue and reports its ID, cluster and index.
module find_best_hop (
  input  logic           clock,
  input  logic           nrst,
  find_best_hop_if.slave bus
);

  localparam logic [15:0] ADDR_COUNT   = 16'h068A;
  localparam logic [15:0] BASE_BATTERY = 16'h0148;
  localparam logic [15:0] BASE_QVALUE  = 16'h01C8;
  localparam logic [15:0] BASE_ID      = 16'h0048;
  localparam logic [15:0] BASE_CLUSTER = 16'h00C8;
  localparam logic [15:0] MAX_COUNT    = 16'd64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_CNT = 3'd1,
    S_CHK = 3'd2,
    S_BAT = 3'd3,
    S_Q   = 3'd4,
    S_ID  = 3'd5,
    S_CL  = 3'd6
  } state_t;

  state_t      state_r;
  logic [15:0] n_r;
  logic [15:0] count_r;
  logic [15:0] address_r;
  logic [15:0] best_id_r;
  logic [15:0] best_q_r;
  logic [15:0] best_cluster_r;
  logic [15:0] best_index_r;
  logic        found_r;
  logic        no_route_r;
  logic        done_r;

  // Each table field is an array of 16-bit entries spaced two words apart.
  function automatic logic [15:0] entry_addr(input logic [15:0] base, input logic [15:0] idx);
    entry_addr = base + {idx[14:0], 1'b0};
  endfunction

  assign bus.address     = address_r;
  assign bus.wr_en       = 1'b0;
  assign bus.bestID      = best_id_r;
  assign bus.bestQ       = best_q_r;
  assign bus.bestCluster = best_cluster_r;
  assign bus.bestIndex   = best_index_r;
  assign bus.noRoute     = no_route_r;
  assign bus.done        = done_r;

  // Scan sequencer: walks the table one read per state and keeps the running best.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_r        <= IDLE;
      n_r            <= 16'd0;
      count_r        <= 16'd0;
      address_r      <= 16'd0;
      best_id_r      <= 16'd0;
      best_q_r       <= 16'd0;
      best_cluster_r <= 16'd0;
      best_index_r   <= 16'd0;
      found_r        <= 1'b0;
      no_route_r     <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.en) begin
            done_r       <= 1'b0;
            no_route_r   <= 1'b0;
            best_q_r     <= 16'd0;
            best_index_r <= 16'd0;
            found_r      <= 1'b0;
            n_r          <= 16'd0;
            address_r    <= ADDR_COUNT;
            state_r      <= S_CNT;
          end
        end
        S_CNT: begin
          count_r <= (bus.data_in > MAX_COUNT) ? MAX_COUNT : bus.data_in;
          state_r <= S_CHK;
        end
        S_CHK: begin
          if (n_r < count_r) begin
            address_r <= entry_addr(BASE_BATTERY, n_r);
            state_r   <= S_BAT;
          end else if (found_r) begin
            address_r <= entry_addr(BASE_ID, best_index_r);
            state_r   <= S_ID;
          end else begin
            no_route_r <= 1'b1;
            done_r     <= 1'b1;
            state_r    <= IDLE;
          end
        end
        S_BAT: begin
          if (bus.data_in < bus.minBattery) begin
            n_r     <= n_r + 16'd1;
            state_r <= S_CHK;
          end else begin
            address_r <= entry_addr(BASE_QVALUE, n_r);
            state_r   <= S_Q;
          end
        end
        S_Q: begin
          // Strict less-than keeps the lower index on equal qValues.
          if (!found_r || (bus.data_in < best_q_r)) begin
            best_q_r     <= bus.data_in;
            best_index_r <= n_r;
            found_r      <= 1'b1;
          end
          n_r     <= n_r + 16'd1;
          state_r <= S_CHK;
        end
        S_ID: begin
          best_id_r <= bus.data_in;
          address_r <= entry_addr(BASE_CLUSTER, best_index_r);
          state_r   <= S_CL;
        end
        S_CL: begin
          best_cluster_r <= bus.data_in;
          done_r         <= 1'b1;
          state_r        <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
